// File: rtl/dma_out_streamer_if.sv
// Write port, send request and AXI-Stream master signals of the DMA output streamer.
// slave: the streamer itself; master: the datapath/DMA side driving it.
interface dma_out_streamer_if;
  logic        we;
  logic [2:0]  wr_addr;
  logic [63:0] din;
  logic        send;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tkeep;
  logic        full;
  logic        busy;
  logic        done;

  modport slave (
    input  we, wr_addr, din, send, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, full, busy, done
  );

  modport master (
    output we, wr_addr, din, send, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, full, busy, done
  );
endinterface

// File: rtl/dma_out_streamer.sv
// Buffers DEPTH 64-bit result words, then streams them as one AXI-Stream packet.
// First beat appears the cycle after an accepted send; tvalid holds the beat stable under tready=0.
module dma_out_streamer #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dma_out_streamer_if.slave io
);
  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

  localparam logic [3:0] DEPTH_W  = 4'(DEPTH);
  localparam logic [2:0] LAST_PTR = 3'(DEPTH - 1);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        full_q, full_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic        done_q, done_d;
  logic        wr_ok;
  logic        tvalid;
  // Sized for the widest legal DEPTH so the 3-bit address indexes it directly.
  logic [63:0] mem [0:7];

  assign wr_ok = (state_q == FILL) && io.we && ({1'b0, io.wr_addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wcnt_q   <= '0;
      full_q   <= 1'b0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      full_q   <= full_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end

  // Storage is not reset; contents survive until rewritten.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[io.wr_addr] <= io.din;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (wr_ok && (wcnt_q != DEPTH_W)) begin
          wcnt_d = wcnt_q + 4'd1;
        end
        // Uses the registered full, so a write completing the fill cannot launch the packet.
        if (io.send && full_q) begin
          state_d  = SEND;
          rd_ptr_d = '0;
        end
      end
      SEND: begin
        if (io.m_axis_tready) begin
          if (rd_ptr_q == LAST_PTR) begin
            state_d  = FILL;
            rd_ptr_d = '0;
            wcnt_d   = '0;
            done_d   = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 3'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase
    full_d = (wcnt_d == DEPTH_W);
  end

  assign tvalid           = (state_q == SEND);
  assign io.m_axis_tvalid = tvalid;
  assign io.m_axis_tdata  = tvalid ? mem[rd_ptr_q] : 64'd0;
  assign io.m_axis_tlast  = tvalid && (rd_ptr_q == LAST_PTR);
  assign io.m_axis_tkeep  = tvalid ? 8'hFF : 8'h00;
  assign io.full          = full_q;
  assign io.busy          = tvalid;
  assign io.done          = done_q;
endmodule
